mbc_banker: RTL and testbench

MBC_BANKER -- requirements
Module: mbc_banker

---
 rtl/mbc_banker.sv | 90 +++++++++
 tb/tb_mbc_banker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbc_banker.sv
// MBC1-style cartridge bank controller: decodes CPU writes into ROM/RAM bank registers.
// Define MBC_CART_RAM_EN to build cart RAM enable, select, write pulse and RAM banking.
module mbc_banker #(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2
) (
    input  logic                       clock4,
    input  logic                       reset,
    input  logic [15:0]                address,
    input  logic [7:0]                 indata,
    input  logic                       store,
    input  logic                       load,
    output logic [ROM_BANK_BITS+13:0]  rom_address,
    output logic [RAM_BANK_BITS+12:0]  ram_address,
    output logic                       ram_select,
    output logic                       ram_write
);

    logic       store_q;
    logic       write_event;
    logic [4:0] low5;
    logic [1:0] upper2;
    logic       mode;
    logic [6:0] bank_full;
    logic [6:0] base_full;
    logic       unused_bits;

`ifdef MBC_CART_RAM_EN
    logic       ram_enable;
`endif

    // A long store strobe yields one event: only its first cycle sees store_q low.
    assign write_event = store & ~store_q;

    // NOTE: store_q resets high so a store held across reset release is already consumed.
    always_ff @(posedge clock4) begin
        if (reset) begin
            store_q <= 1'b1;
            low5    <= 5'h01;
            upper2  <= 2'b00;
            mode    <= 1'b0;
`ifdef MBC_CART_RAM_EN
            ram_enable <= 1'b0;
`endif
        end else begin
            store_q <= store;
            if (write_event) begin
                case (address[15:13])
`ifdef MBC_CART_RAM_EN
                    3'b000:  ram_enable <= (indata[3:0] == 4'hA);
`endif
                    3'b001:  low5   <= (indata[4:0] == 5'h00) ? 5'h01 : indata[4:0];
                    3'b010:  upper2 <= indata[1:0];
                    3'b011:  mode   <= indata[0];
                    default: ;
                endcase
            end
        end
    end

    assign bank_full = {upper2, low5};
    assign base_full = mode ? {upper2, 5'b00000} : 7'b0000000;

    always_comb begin
        if (address[15:14] == 2'b00) begin
            rom_address = {base_full[ROM_BANK_BITS-1:0], address[13:0]};
        end else begin
            rom_address = {bank_full[ROM_BANK_BITS-1:0], address[13:0]};
        end
    end

`ifdef MBC_CART_RAM_EN
    logic                     in_ram_window;
    logic [RAM_BANK_BITS-1:0] ram_bank;

    assign in_ram_window = (address[15:13] == 3'b101);
    assign ram_bank      = mode ? upper2[RAM_BANK_BITS-1:0] : {RAM_BANK_BITS{1'b0}};
    assign ram_select    = in_ram_window & ram_enable;
    assign ram_write     = write_event & ram_select & ~reset;
    assign ram_address   = {ram_bank, address[12:0]};
`else
    assign ram_select    = 1'b0;
    assign ram_write     = 1'b0;
    assign ram_address   = '0;
`endif

    // Reads never alter state; bank bits above ROM_BANK_BITS are dropped by design.
    assign unused_bits = ^{load, indata[7:5], bank_full, base_full, upper2};

endmodule

// File: tb/tb_mbc_banker.sv
// Scoreboard bench for mbc_banker: driver pushes model expectations on every load cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mbc_banker;

    localparam int ROM_BANK_BITS = 7;
    localparam int RAM_BANK_BITS = 2;
    localparam int ROMW = ROM_BANK_BITS + 14;
    localparam int RAMW = RAM_BANK_BITS + 13;
`ifdef MBC_CART_RAM_EN
    localparam bit HAS_RAM = 1'b1;
`else
    localparam bit HAS_RAM = 1'b0;
`endif

    logic            clock4 = 1'b0;
    logic            reset;
    logic [15:0]     address;
    logic [7:0]      indata;
    logic            store;
    logic            load;
    logic [ROMW-1:0] rom_address;
    logic [RAMW-1:0] ram_address;
    logic            ram_select;
    logic            ram_write;

    mbc_banker #(
        .ROM_BANK_BITS(ROM_BANK_BITS),
        .RAM_BANK_BITS(RAM_BANK_BITS)
    ) dut (
        .clock4     (clock4),
        .reset      (reset),
        .address    (address),
        .indata     (indata),
        .store      (store),
        .load       (load),
        .rom_address(rom_address),
        .ram_address(ram_address),
        .ram_select (ram_select),
        .ram_write  (ram_write)
    );

    always #5 clock4 = ~clock4;

    typedef struct {
        logic [15:0]     addr;
        logic [ROMW-1:0] rom;
        logic [RAMW-1:0] ram;
        logic            sel;
        logic            wr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: bank register contents as plain integers.
    int m_low5, m_upper2, m_mode, m_ram_en;
    bit prev_store;

    task automatic check(input string name, input logic [15:0] a,
                         input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s addr=%h: got %0h expected %0h", name, a, got, exp);
        end
    endtask

    function automatic logic [ROMW-1:0] exp_rom(input logic [15:0] a);
        longint b;
        if (a < 16'h4000) b = (m_mode != 0) ? m_upper2 * 32 : 0;
        else              b = m_upper2 * 32 + m_low5;
        return ROMW'(b * 16384 + longint'(a & 16'h3FFF));
    endfunction

    function automatic logic [RAMW-1:0] exp_ram(input logic [15:0] a);
        int bank;
        if (!HAS_RAM) return '0;
        bank = (m_mode != 0) ? m_upper2 % (1 << RAM_BANK_BITS) : 0;
        return RAMW'(bank * 8192 + int'(a & 16'h1FFF));
    endfunction

    function automatic bit exp_sel(input logic [15:0] a);
        return HAS_RAM && (a >= 16'hA000) && (a <= 16'hBFFF) && (m_ram_en != 0);
    endfunction

    task automatic model_reset();
        m_low5 = 1; m_upper2 = 0; m_mode = 0; m_ram_en = 0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (a < 16'h2000) begin
            if (HAS_RAM) m_ram_en = (d[3:0] == 4'hA) ? 1 : 0;
        end else if (a < 16'h4000) begin
            m_low5 = int'(d[4:0]);
            if (m_low5 == 0) m_low5 = 1;
        end else if (a < 16'h6000) begin
            m_upper2 = int'(d[1:0]);
        end else if (a < 16'h8000) begin
            m_mode = int'(d[0]);
        end
    endtask

    // One bus cycle: inputs change just after a rising edge, sampled by the monitor at negedge.
    task automatic drive(input logic rst, input logic [15:0] a, input logic [7:0] d,
                         input logic st, input logic ld);
        exp_t e;
        bit   ev;
        reset = rst; address = a; indata = d; store = st; load = ld;
        ev = st && !prev_store && !rst;
        if (ld) begin
            e.addr = a;
            e.rom  = exp_rom(a);
            e.ram  = exp_ram(a);
            e.sel  = exp_sel(a);
            e.wr   = ev && exp_sel(a);
            sb.push_back(e);
        end
        if (rst)     model_reset();
        else if (ev) model_write(a, d);
        prev_store = rst ? 1'b1 : st;
        @(posedge clock4);
        #1;
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        drive(1'b0, a, d, 1'b1, 1'b0);
        drive(1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic read(input logic [15:0] a);
        drive(1'b0, a, 8'h00, 1'b0, 1'b1);
    endtask

    always @(negedge clock4) begin
        exp_t e;
        if (load === 1'b1) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", address, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rom_address", e.addr, 32'(rom_address), 32'(e.rom));
                check("ram_address", e.addr, 32'(ram_address), 32'(e.ram));
                check("ram_select",  e.addr, 32'(ram_select),  32'(e.sel));
                check("ram_write",   e.addr, 32'(ram_write),   32'(e.wr));
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rr;
        logic        st;

        prev_store = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);

        // Reset state: bank 1 in the switchable window, bank 0 below it, RAM deselected.
        read(16'h4000);
        read(16'h0000);
        read(16'hA000);

        // Bank 0 written maps to bank 1; bank 0x1F at the top of the window.
        write(16'h2000, 8'h00);
        read(16'h4000);
        write(16'h2000, 8'h1F);
        read(16'h7FFF);

        // Upper bits give bank 0x61; mode 1 also banks the fixed window.
        write(16'h4000, 8'h03);
        write(16'h2000, 8'h00);
        read(16'h4000);
        write(16'h6000, 8'h01);
        read(16'h0000);

        // Held strobe with changing data: only the first cycle's data lands.
        drive(1'b0, 16'h2000, 8'h02, 1'b1, 1'b0);
        drive(1'b0, 16'h2000, 8'h03, 1'b1, 1'b1);
        drive(1'b0, 16'h2000, 8'h04, 1'b1, 1'b0);
        drive(1'b0, 16'h2000, 8'h05, 1'b1, 1'b1);
        drive(1'b0, 16'h2000, 8'h05, 1'b1, 1'b0);
        drive(1'b0, 16'h2000, 8'h05, 1'b0, 1'b0);
        read(16'h4000);

        // Cart RAM: enable, bank 2, one write pulse with load held as well.
        write(16'h0000, 8'h0A);
        write(16'h6000, 8'h01);
        write(16'h4000, 8'h02);
        drive(1'b0, 16'hA123, 8'h55, 1'b1, 1'b1);
        drive(1'b0, 16'hA123, 8'h55, 1'b1, 1'b1);
        drive(1'b0, 16'hA123, 8'h55, 1'b0, 1'b0);
        read(16'hA123);
        read(16'h4000);
        write(16'h0000, 8'h00);
        read(16'hA123);

        // Writes outside the register windows are ignored.
        write(16'h8000, 8'h1F);
        write(16'hC000, 8'h1F);
        write(16'hFFFF, 8'h1F);
        read(16'h4000);

        // Reset arriving with the strobe, store held through release.
        write(16'h4000, 8'h00);
        write(16'h2000, 8'h1F);
        read(16'h4000);
        drive(1'b1, 16'h2000, 8'h05, 1'b1, 1'b0);
        drive(1'b1, 16'h2000, 8'h05, 1'b1, 1'b0);
        drive(1'b0, 16'h2000, 8'h05, 1'b1, 1'b1);
        drive(1'b0, 16'h2000, 8'h07, 1'b1, 1'b1);
        drive(1'b0, 16'h2000, 8'h07, 1'b0, 1'b0);
        drive(1'b0, 16'h2000, 8'h03, 1'b1, 1'b0);
        drive(1'b0, 16'h2000, 8'h03, 1'b0, 1'b0);
        read(16'h4000);

        // Randomised traffic biased toward the register windows.
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[15] = 1'b0;
            if ($urandom_range(0, 5) == 0) ra[15:13] = 3'b101;
            rd = 8'($urandom);
            if ($urandom_range(0, 2) == 0) st = ~st;
            rr = ($urandom_range(0, 59) == 0);
            drive(rr, ra, rd, st, 1'($urandom));
        end

        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        check("scoreboard_drain", 16'h0000, 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
